riscv_seq_ctrl: RTL and testbench

Multi-cycle control sequencer that drives the single-issue ALU datapath (register file, ALU, branch comparator).
- Fetches 32-bit instructions from an instruction memory over a req/valid handshake.
- Decodes R (0110011), I (0010011) and B (1100011) opcodes, presents the instruction and decoded ALU controls to the datapath, and pulses register write-enable.
- Updates the PC from the datapath's branch-taken flag.
- Traps on illegal encodings or fetch timeout.

---
 rtl/riscv_ctrl_pkg.sv | 59 +++++
 rtl/riscv_decode.sv | 55 +++++
 rtl/riscv_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_riscv_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================
// riscv_ctrl_pkg : opcodes, funct3 encodings and enums shared by the sequencer
// Rev 1.0
// ============================================================
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [2:0] {
        F3_ADD = 3'd0,
        F3_SUB = 3'd1,
        F3_OR  = 3'd2,
        F3_AND = 3'd3,
        F3_XOR = 3'd4
    } r_funct3_e;

    typedef enum logic [2:0] {
        F3_ADDI = 3'd0,
        F3_SUBI = 3'd1
    } i_funct3_e;

    typedef enum logic [2:0] {
        F3_BEQ = 3'd0,
        F3_BNQ = 3'd1,
        F3_BLT = 3'd2,
        F3_BGT = 3'd3
    } b_funct3_e;

    typedef enum logic [1:0] {
        ALU_R = 2'b00,
        ALU_I = 2'b01,
        ALU_B = 2'b10
    } alu_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_TIMEOUT = 2'b10
    } trap_code_e;

    // B-type immediate, bit 0 implied zero, sign-extended to 32 bits.
    function automatic logic [31:0] b_imm_sext(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_decode.sv
`default_nettype none
// ============================================================
// riscv_decode : combinational opcode/funct3 decode for R, I and B formats
// Rev 1.0
// ============================================================
module riscv_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [1:0]  alu_sel,
    output logic [2:0]  alu_control,
    output logic        writes_reg,
    output logic        is_branch,
    output logic        legal,
    output logic [31:0] b_imm
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused;

    assign w_opcode    = instr[6:0];
    assign w_funct3    = instr[14:12];
    assign alu_control = w_funct3;
    assign b_imm       = b_imm_sext(instr);
    // Register specifiers are routed by the datapath from instr directly.
    assign w_unused    = ^instr[24:15];

    always_comb begin
        alu_sel    = ALU_R;
        writes_reg = 1'b0;
        is_branch  = 1'b0;
        legal      = 1'b0;
        case (w_opcode)
            OP_R: begin
                alu_sel    = ALU_R;
                writes_reg = 1'b1;
                legal      = (w_funct3 <= F3_XOR);
            end
            OP_I: begin
                alu_sel    = ALU_I;
                writes_reg = 1'b1;
                legal      = (w_funct3 <= F3_SUBI);
            end
            OP_B: begin
                alu_sel   = ALU_B;
                is_branch = 1'b1;
                legal     = (w_funct3 <= F3_BGT);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_seq_ctrl.sv
`default_nettype none
// ============================================================
// riscv_seq_ctrl : multi-cycle fetch/decode/exec/writeback control sequencer
// Rev 1.0
// ============================================================
module riscv_seq_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          EXEC_CYCLES = 1,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [1:0]  alu_sel,
    output logic [2:0]  alu_control,
    input  logic        bt,
    output logic        reg_write,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_code
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [3:0]        r_exec_cnt;
    logic [31:0]       r_instr;
    logic [31:0]       r_pc;
    logic [31:0]       r_retired;
    logic [31:0]       r_b_imm;
    logic [1:0]        r_alu_sel;
    logic [2:0]        r_alu_control;
    logic              r_writes_reg;
    logic              r_is_branch;
    logic              r_bt;
    logic              r_trap;
    trap_code_e        r_trap_code;

    logic [1:0]        w_dec_alu_sel;
    logic [2:0]        w_dec_alu_control;
    logic              w_dec_writes_reg;
    logic              w_dec_is_branch;
    logic              w_dec_legal;
    logic [31:0]       w_dec_b_imm;
    logic              w_wait_expired;
    logic              w_exec_last;
    logic [31:0]       w_pc_nxt;

    riscv_decode u_decode (
        .instr       (imem_rdata),
        .alu_sel     (w_dec_alu_sel),
        .alu_control (w_dec_alu_control),
        .writes_reg  (w_dec_writes_reg),
        .is_branch   (w_dec_is_branch),
        .legal       (w_dec_legal),
        .b_imm       (w_dec_b_imm)
    );

    assign w_wait_expired = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign w_exec_last    = (r_exec_cnt == 4'(EXEC_CYCLES));
    assign w_pc_nxt       = (r_is_branch && r_bt) ? (r_pc + r_b_imm) : (r_pc + 32'd4);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (run) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (imem_valid)
                    w_state_nxt = w_dec_legal ? ST_EXEC : ST_TRAP;
                else if (w_wait_expired)
                    w_state_nxt = ST_TRAP;
            end
            ST_EXEC:  if (w_exec_last) w_state_nxt = ST_WB;
            ST_WB:    w_state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_TRAP:  w_state_nxt = ST_TRAP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_exec_cnt    <= '0;
            r_instr       <= '0;
            r_pc          <= RESET_PC;
            r_retired     <= '0;
            r_b_imm       <= '0;
            r_alu_sel     <= ALU_R;
            r_alu_control <= '0;
            r_writes_reg  <= 1'b0;
            r_is_branch   <= 1'b0;
            r_bt          <= 1'b0;
            r_trap        <= 1'b0;
            r_trap_code   <= TRAP_NONE;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE:  if (run) r_pc <= RESET_PC;
                ST_FETCH: r_wait_cnt <= WAIT_W'(1);
                ST_WAIT: begin
                    if (imem_valid) begin
                        // Illegal encodings leave every datapath-facing register untouched.
                        if (w_dec_legal) begin
                            r_instr       <= imem_rdata;
                            r_alu_sel     <= w_dec_alu_sel;
                            r_alu_control <= w_dec_alu_control;
                            r_writes_reg  <= w_dec_writes_reg;
                            r_is_branch   <= w_dec_is_branch;
                            r_b_imm       <= w_dec_b_imm;
                            r_exec_cnt    <= 4'd1;
                        end else begin
                            r_trap      <= 1'b1;
                            r_trap_code <= TRAP_ILLEGAL;
                        end
                    end else if (w_wait_expired) begin
                        r_trap      <= 1'b1;
                        r_trap_code <= TRAP_TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (w_exec_last) r_bt <= bt;
                    else             r_exec_cnt <= r_exec_cnt + 4'd1;
                end
                ST_WB: begin
                    r_pc      <= w_pc_nxt;
                    r_retired <= r_retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ST_EXEC) || (r_state == ST_WB);
    assign alu_sel     = r_alu_sel;
    assign alu_control = r_alu_control;
    assign reg_write   = (r_state == ST_WB) && r_writes_reg;
    assign pc          = r_pc;
    assign retired     = r_retired;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_TRAP);
    assign trap        = r_trap;
    assign trap_code   = r_trap_code;

endmodule
`default_nettype wire

// File: tb/tb_riscv_seq_ctrl.sv
`default_nettype none
// ============================================================
// tb_riscv_seq_ctrl : directed self-checking bench for riscv_seq_ctrl
// Rev 1.0
// ============================================================
module tb_riscv_seq_ctrl;

    localparam logic [31:0] INS_ADD  = 32'h0010_8533;
    localparam logic [31:0] INS_BEQ  = 32'h015A_8563;
    localparam logic [31:0] INS_SUBI = 32'h0010_1093;
    localparam logic [31:0] INS_BNEG = 32'hFE00_0EE3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [1:0]  alu_sel;
    logic [2:0]  alu_control;
    logic        bt = 1'b0;
    logic        reg_write;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        busy;
    logic        trap;
    logic [1:0]  trap_code;

    int n_checks = 0;
    int n_errors = 0;

    riscv_seq_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .EXEC_CYCLES (1),
        .MEM_TIMEOUT (16)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .alu_sel     (alu_sel),
        .alu_control (alu_control),
        .bt          (bt),
        .reg_write   (reg_write),
        .pc          (pc),
        .retired     (retired),
        .busy        (busy),
        .trap        (trap),
        .trap_code   (trap_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        imem_valid = 1'b0;
        bt = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Entered at a FETCH sample point; leaves at the following FETCH/IDLE sample point.
    task automatic run_instr(input logic [31:0] ins, input logic btv);
        imem_valid = 1'b1;
        imem_rdata = ins;
        tick();
        tick();
        imem_valid = 1'b0;
        bt = btv;
        tick();
        bt = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if ({pc, instr, retired} !== 96'h0) begin n_errors++; $display("FAIL reset_regs got pc=%h instr=%h ret=%h want 0", pc, instr, retired); end
        n_checks++; if ({imem_req, instr_valid, reg_write, busy, trap} !== 5'b0) begin n_errors++; $display("FAIL reset_strobes got %b want 00000", {imem_req, instr_valid, reg_write, busy, trap}); end
        n_checks++; if ({alu_sel, alu_control, trap_code} !== 7'b0) begin n_errors++; $display("FAIL reset_ctrl got %b want 0000000", {alu_sel, alu_control, trap_code}); end
    endtask

    task automatic test_r_add();
        run = 1'b1;
        tick();
        n_checks++; if ({imem_req, busy, imem_addr} !== {2'b11, 32'h0}) begin n_errors++; $display("FAIL add_fetch got req=%b busy=%b addr=%h want 1 1 0", imem_req, busy, imem_addr); end
        imem_valid = 1'b1;
        imem_rdata = INS_ADD;
        tick();
        n_checks++; if ({imem_req, instr_valid} !== 2'b00) begin n_errors++; $display("FAIL add_wait got req=%b iv=%b want 0 0", imem_req, instr_valid); end
        tick();
        imem_valid = 1'b0;
        n_checks++; if ({instr_valid, reg_write, alu_sel, alu_control} !== 7'b1000000 || instr !== INS_ADD) begin n_errors++; $display("FAIL add_exec got iv=%b rw=%b sel=%b ctl=%b instr=%h", instr_valid, reg_write, alu_sel, alu_control, instr); end
        tick();
        n_checks++; if ({reg_write, instr_valid} !== 2'b11 || pc !== 32'h0) begin n_errors++; $display("FAIL add_wb got rw=%b iv=%b pc=%h want 1 1 0", reg_write, instr_valid, pc); end
        tick();
        n_checks++; if (pc !== 32'h4 || retired !== 32'd1 || reg_write !== 1'b0 || imem_req !== 1'b1) begin n_errors++; $display("FAIL add_retire got pc=%h ret=%0d rw=%b req=%b want 4 1 0 1", pc, retired, reg_write, imem_req); end
    endtask

    task automatic test_branch();
        run_instr(INS_ADD, 1'b0);
        run_instr(INS_ADD, 1'b0);
        run_instr(INS_ADD, 1'b0);
        n_checks++; if (pc !== 32'h10 || retired !== 32'd4) begin n_errors++; $display("FAIL b2b_pc got pc=%h ret=%0d want 10 4", pc, retired); end
        imem_valid = 1'b1;
        imem_rdata = INS_BEQ;
        tick();
        tick();
        imem_valid = 1'b0;
        bt = 1'b1;
        n_checks++; if (alu_sel !== 2'b10 || alu_control !== 3'b000) begin n_errors++; $display("FAIL beq_sel got sel=%b ctl=%b want 10 000", alu_sel, alu_control); end
        tick();
        bt = 1'b0;
        n_checks++; if (reg_write !== 1'b0 || instr_valid !== 1'b1) begin n_errors++; $display("FAIL beq_wb got rw=%b iv=%b want 0 1", reg_write, instr_valid); end
        tick();
        n_checks++; if (pc !== 32'h1A || retired !== 32'd5) begin n_errors++; $display("FAIL beq_taken got pc=%h ret=%0d want 1a 5", pc, retired); end
        run_instr(INS_BEQ, 1'b0);
        n_checks++; if (pc !== 32'h1E || retired !== 32'd6) begin n_errors++; $display("FAIL beq_not_taken got pc=%h ret=%0d want 1e 6", pc, retired); end
    endtask

    task automatic test_itype();
        imem_valid = 1'b1;
        imem_rdata = INS_SUBI;
        tick();
        tick();
        imem_valid = 1'b0;
        n_checks++; if (alu_sel !== 2'b01 || alu_control !== 3'b001) begin n_errors++; $display("FAIL subi_sel got sel=%b ctl=%b want 01 001", alu_sel, alu_control); end
        tick();
        n_checks++; if (reg_write !== 1'b1) begin n_errors++; $display("FAIL subi_rw got %b want 1", reg_write); end
        tick();
        n_checks++; if (pc !== 32'h22 || alu_sel !== 2'b01) begin n_errors++; $display("FAIL subi_pc got pc=%h sel=%b want 22 01", pc, alu_sel); end
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1;
        tick();
        run_instr(INS_BNEG, 1'b1);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL neg_branch got addr=%h want fffffffc", imem_addr); end
        run_instr(INS_ADD, 1'b0);
        n_checks++; if (pc !== 32'h0 || retired !== 32'd2) begin n_errors++; $display("FAIL pc_wrap got pc=%h ret=%0d want 0 2", pc, retired); end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [4];
        bad[0] = 32'h0000_5033;
        bad[1] = 32'h0000_2013;
        bad[2] = 32'h0000_4063;
        bad[3] = 32'h0000_0037;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            run = 1'b1;
            tick();
            run_instr(INS_ADD, 1'b0);
            imem_valid = 1'b1;
            imem_rdata = bad[k];
            tick();
            tick();
            imem_valid = 1'b0;
            n_checks++; if (trap !== 1'b1 || trap_code !== 2'b01 || instr_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL illegal_%0d got trap=%b code=%b iv=%b busy=%b want 1 01 0 0", k, trap, trap_code, instr_valid, busy); end
            n_checks++; if (pc !== 32'h4 || retired !== 32'd1 || instr !== INS_ADD) begin n_errors++; $display("FAIL illegal_hold_%0d got pc=%h ret=%0d instr=%h want 4 1 %h", k, pc, retired, instr, INS_ADD); end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (trap !== 1'b1 || trap_code !== 2'b01 || {imem_req, instr_valid, reg_write} !== 3'b000) begin n_errors++; $display("FAIL trap_sticky got trap=%b code=%b strobes=%b", trap, trap_code, {imem_req, instr_valid, reg_write}); end
        end
        do_reset();
        run = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || trap !== 1'b0 || trap_code !== 2'b00) begin n_errors++; $display("FAIL trap_restart got req=%b addr=%h trap=%b code=%b want 1 0 0 00", imem_req, imem_addr, trap, trap_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1;
        tick();
        tick();
        repeat (15) tick();
        n_checks++; if (trap !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL timeout_early got trap=%b busy=%b want 0 1", trap, busy); end
        tick();
        n_checks++; if (trap !== 1'b1 || trap_code !== 2'b10 || busy !== 1'b0) begin n_errors++; $display("FAIL timeout_trap got trap=%b code=%b busy=%b want 1 10 0", trap, trap_code, busy); end
        do_reset();
        run = 1'b1;
        tick();
        tick();
        repeat (15) tick();
        imem_valid = 1'b1;
        imem_rdata = INS_SUBI;
        tick();
        imem_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || trap !== 1'b0 || instr !== INS_SUBI) begin n_errors++; $display("FAIL timeout_edge_ok got iv=%b trap=%b instr=%h want 1 0 %h", instr_valid, trap, instr, INS_SUBI); end
    endtask

    task automatic test_run_drop();
        run = 1'b0;
        tick();
        n_checks++; if (reg_write !== 1'b1) begin n_errors++; $display("FAIL drop_wb got rw=%b want 1", reg_write); end
        tick();
        n_checks++; if (busy !== 1'b0 || retired !== 32'd1 || pc !== 32'h4) begin n_errors++; $display("FAIL drop_idle got busy=%b ret=%0d pc=%h want 0 1 4", busy, retired, pc); end
        tick();
        n_checks++; if (imem_req !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL drop_stay got req=%b busy=%b want 0 0", imem_req, busy); end
        run = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL drop_restart got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = INS_ADD;
        tick();
        imem_valid = 1'b0;
        n_checks++; if ({pc, instr, retired} !== 96'h0) begin n_errors++; $display("FAIL rst_wait_regs got pc=%h instr=%h ret=%h want 0", pc, instr, retired); end
        n_checks++; if ({imem_req, instr_valid, reg_write, busy, trap, alu_sel, alu_control, trap_code} !== 12'h0) begin n_errors++; $display("FAIL rst_wait_ctrl got %b want 0", {imem_req, instr_valid, reg_write, busy, trap, alu_sel, alu_control, trap_code}); end
        tick();
        n_checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_wait_idle got iv=%b busy=%b want 0 0", instr_valid, busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_r_add();
        test_branch();
        test_itype();
        test_wrap();
        test_illegal();
        test_timeout();
        test_run_drop();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
